// File: rtl/mp_add_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fa_nbit
//   Plain WIDTH-bit ripple-carry adder: {cout, sum} = a + b + cin.
// ---------------------------------------------------------------------------
// Ports
//   a, b  : WIDTH-bit addends
//   cin   : carry into bit 0
//   sum   : WIDTH-bit sum
//   cout  : carry out of bit WIDTH-1
// ---------------------------------------------------------------------------
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
module fa_nbit #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] w_carry;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
    assign w_carry[i+1] = (a[i] & b[i]) | (a[i] & w_carry[i]) | (b[i] & w_carry[i]);
  end

  assign cout = w_carry[WIDTH];

endmodule

// ---------------------------------------------------------------------------
// mp_add_seq
//   Multi-precision add/subtract sequencer. Two NWORDS*WIDTH-bit operands are
//   combined one WIDTH-bit word per cycle, least significant word first,
//   through a single shared fa_nbit; the inter-word carry lives in a register.
// ---------------------------------------------------------------------------
// Ports
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   start    : request, accepted in IDLE or DONE
//   sub      : 0 = a+b+cin, 1 = a-b (cin ignored)
//   cin      : carry-in for add mode
//   a, b     : operands, sampled at acceptance
//   busy     : high while words are being processed
//   done     : one-cycle pulse when the result is complete
//   s        : result register (valid from done onward)
//   cout     : carry out of the top word (subtract: 1 = no borrow)
//   overflow : two's-complement overflow of the full-width operation
// ---------------------------------------------------------------------------
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
module mp_add_seq #(
  parameter int WIDTH  = 6,
  parameter int NWORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    sub,
  input  logic                    cin,
  input  logic [WIDTH*NWORDS-1:0] a,
  input  logic [WIDTH*NWORDS-1:0] b,
  output logic                    busy,
  output logic                    done,
  output logic [WIDTH*NWORDS-1:0] s,
  output logic                    cout,
  output logic                    overflow
);

  localparam int TW = WIDTH * NWORDS;
  localparam int IW = $clog2(NWORDS);
  localparam logic [IW-1:0] C_LAST_IDX = IW'(NWORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TW-1:0]    r_a;
  logic [TW-1:0]    r_b;
  logic             r_carry;
  logic [IW-1:0]    r_idx;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_a_word;
  logic [WIDTH-1:0] w_b_word;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_idx == C_LAST_IDX);

  // Status flags are pure state decodes, so an asynchronous reset clears them
  // immediately along with the state register.
  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- word select
  always_comb begin
    w_a_word = '0;
    w_b_word = '0;
    for (int i = 0; i < NWORDS; i++) begin
      if (r_idx == IW'(i)) begin
        w_a_word = r_a[i*WIDTH +: WIDTH];
        w_b_word = r_b[i*WIDTH +: WIDTH];
      end
    end
  end

  fa_nbit #(
    .WIDTH (WIDTH)
  ) u_fa (
    .a    (w_a_word),
    .b    (w_b_word),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      s        <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub ? 1'b1 : cin;
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      for (int i = 0; i < NWORDS; i++) begin
        if (r_idx == IW'(i)) begin
          s[i*WIDTH +: WIDTH] <= w_sum;
        end
      end
      r_carry <= w_cout;
      if (w_last) begin
        cout     <= w_cout;
        overflow <= (r_a[TW-1] == r_b[TW-1]) && (w_sum[WIDTH-1] != r_a[TW-1]);
      end else begin
        // Held at the last index rather than wrapping past NWORDS-1.
        r_idx <= r_idx + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mp_add_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mp_add_seq
//   Directed, table-driven bench for mp_add_seq (WIDTH=6, NWORDS=4).
// ---------------------------------------------------------------------------
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
module tb_mp_add_seq;

  localparam int WIDTH  = 6;
  localparam int NWORDS = 4;
  localparam int TW     = WIDTH * NWORDS;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          sub;
  logic          cin;
  logic [TW-1:0] a;
  logic [TW-1:0] b;
  logic          busy;
  logic          done;
  logic [TW-1:0] s;
  logic          cout;
  logic          overflow;

  int n_cmp;
  int n_err;

  mp_add_seq #(
    .WIDTH  (WIDTH),
    .NWORDS (NWORDS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .cin      (cin),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .s        (s),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          sub;
    logic          cin;
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic [TW-1:0] exp_s;
    logic          exp_cout;
    logic          exp_ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Accept one operation, then track busy/done until done or a cycle budget.
  task automatic run_op(input vec_t v, output int lat, output int busy_cyc);
    @(negedge clk);
    sub   = v.sub;
    cin   = v.cin;
    a     = v.a;
    b     = v.b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    lat      = 0;
    busy_cyc = 0;
    while (!done && lat < 12) begin
      if (busy) busy_cyc++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int bc;
    logic [TW-1:0] hold_s;

    n_cmp = 0;
    n_err = 0;

    //         sub   cin   a            b            s            cout  ovf
    vecs[0] = '{1'b0, 1'b0, 24'hFFFFFF, 24'h000001, 24'h000000, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 24'h000010, 24'h000020, 24'hFFFFF0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 24'h7FFFFF, 24'h000000, 24'h800000, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 24'h123456, 24'h654321, 24'h777777, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 24'h800000, 24'h000001, 24'h7FFFFF, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 24'h555555, 24'h555555, 24'h000000, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 24'h800000, 24'h800000, 24'h000000, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 24'h000FFF, 24'h000000, 24'h001000, 1'b0, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    cin   = 1'b0;
    a     = '0;
    b     = '0;
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_s", 32'(s), 32'd0);
    chk("reset_cout", 32'(cout), 32'd0);
    chk("reset_ovf", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle stability straight after reset.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b0 || done !== 1'b0 || s !== '0) begin
        chk("idle_after_reset", {busy, done, 30'(s)}, 32'd0);
      end
    end
    chk("idle_end_flags", {30'd0, busy, done}, 32'd0);
    chk("idle_end_s", 32'(s), 32'd0);

    // Table of single operations.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i], lat, bc);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
      chk($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'd4);
      chk($sformatf("v%0d_s", i), 32'(s), 32'(vecs[i].exp_s));
      chk($sformatf("v%0d_cout", i), 32'(cout), 32'(vecs[i].exp_cout));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_one_cycle", i), 32'(done), 32'd0);
      chk($sformatf("v%0d_idle_busy", i), 32'(busy), 32'd0);
    end

    // Outputs hold with no start.
    hold_s = s;
    repeat (5) @(posedge clk);
    #1;
    chk("hold_s", 32'(s), 32'(hold_s));
    chk("hold_flags", {30'd0, busy, done}, 32'd0);

    // Input isolation, ignored mid-RUN start, then back-to-back from DONE.
    @(negedge clk);
    sub   = 1'b0;
    cin   = 1'b1;
    a     = 24'h000003;
    b     = 24'h000004;
    start = 1'b1;
    @(posedge clk);            // acceptance edge E0
    #1;
    start = 1'b0;
    chk("iso_busy_after_accept", 32'(busy), 32'd1);
    @(negedge clk);
    a   = 24'hABCDEF;
    sub = 1'b1;
    cin = 1'b0;
    @(posedge clk);            // E1
    @(negedge clk);
    start = 1'b1;              // pulse while busy
    @(posedge clk);            // E2
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);            // E3
    @(negedge clk);
    // Second operation, held through E4 (RUN, ignored) and E5 (DONE, accepted).
    sub   = 1'b0;
    cin   = 1'b0;
    a     = 24'h100000;
    b     = 24'h100000;
    start = 1'b1;
    @(posedge clk);            // E4
    #1;
    chk("iso_done_at_e4", 32'(done), 32'd1);
    chk("iso_first_s", 32'(s), 32'h000008);
    chk("iso_first_cout", 32'(cout), 32'd0);
    @(posedge clk);            // E5: back-to-back acceptance
    #1;
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_done_low", 32'(done), 32'd0);
    lat = 0;
    while (!done && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("b2b_latency", 32'(lat), 32'd4);
    chk("b2b_s", 32'(s), 32'h200000);
    chk("b2b_ovf", 32'(overflow), 32'd0);

    // Leave nonzero cout/overflow behind, then reset mid-operation.
    run_op(vecs[6], lat, bc);
    chk("pre_reset_cout", 32'(cout), 32'd1);
    chk("pre_reset_ovf", 32'(overflow), 32'd1);
    @(negedge clk);
    a     = 24'h123456;
    b     = 24'h111111;
    start = 1'b1;
    @(posedge clk);            // acceptance
    #1;
    start = 1'b0;
    @(posedge clk);            // now in 2nd RUN cycle
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_s", 32'(s), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    chk("midrst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) begin
        chk("post_reset_quiet", {30'd0, busy, done}, 32'd0);
      end
    end
    chk("post_reset_end_flags", {30'd0, busy, done}, 32'd0);
    chk("post_reset_end_s", 32'(s), 32'd0);

    // A fresh start still works after the abandoned operation.
    run_op(vecs[3], lat, bc);
    chk("recover_latency", 32'(lat), 32'd4);
    chk("recover_s", 32'(s), 32'h777777);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
